// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared constants, FSM state type and length decode for the fetch unit
package ifu_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] LEN_CODE_2 = 2'b10;
  localparam logic [1:0] LEN_CODE_3 = 2'b11;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifu_state_e;

  // Instruction length in words, taken from the top two bits of the first word.
  function automatic logic [1:0] inst_len(input logic [WORD_W-1:0] word);
    case (word[WORD_W-1 -: 2])
      LEN_CODE_2: return 2'd2;
      LEN_CODE_3: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/ifu_word_queue.sv
// rtl/ifu_word_queue.sv - circular word buffer, 3-word push, 1..3-word pop, synchronous flush
module ifu_word_queue
  import ifu_pkg::*;
#(
  parameter int  DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_w0,
  input  logic [WORD_W-1:0] push_w1,
  input  logic [WORD_W-1:0] push_w2,
  input  logic              pop,
  input  logic [1:0]        pop_len,
  output logic [WORD_W-1:0] head0,
  output logic [WORD_W-1:0] head1,
  output logic [WORD_W-1:0] head2,
  output logic [CW-1:0]     count
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW-1:0]     rd_1, rd_2, wr_1, wr_2;

  // Pointer arithmetic relies on DEPTH being a power of two for free wrap.
  assign rd_1 = rd_ptr + PW'(1);
  assign rd_2 = rd_ptr + PW'(2);
  assign wr_1 = wr_ptr + PW'(1);
  assign wr_2 = wr_ptr + PW'(2);

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_1];
  assign head2 = mem[rd_2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_w0;
        mem[wr_1]   <= push_w1;
        mem[wr_2]   <= push_w2;
        wr_ptr      <= wr_ptr + PW'(3);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(pop_len);
      count <= count + (push ? CW'(3) : CW'(0)) - (pop ? CW'(pop_len) : CW'(0));
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch front end; IFU_STATS_EN adds fetch/stall counters
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          QDEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_inst,
  input  logic [15:0] imem_inst_1,
  input  logic [15:0] imem_inst_2,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_inst,
  output logic [15:0] dec_ext1,
  output logic [15:0] dec_ext2,
  output logic [1:0]  dec_len,
  output logic [15:0] dec_pc
`ifdef IFU_STATS_EN
  ,
  output logic [15:0] stat_fetches,
  output logic [15:0] stat_stalls
`endif
);

  localparam int          CW      = $clog2(QDEPTH) + 1;
  localparam logic [15:0] PC_INIT = RESET_PC & 16'hFFFE;

  ifu_state_e        state, state_next;
  logic [15:0]       fetch_pc, head_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] head0, head1, head2;
  logic [1:0]        len;
  logic              redirect, issue, push, pop, credit_ok;

  assign len      = inst_len(head0);
  assign redirect = redirect_valid && (state != RST);

  // Credit ignores the same-cycle pop, so a granted fetch always has room.
  assign credit_ok = (32'(count) + (inflight ? 32'd3 : 32'd0) + 32'd3) <= 32'(QDEPTH);

  assign dec_valid = (count != '0) && (count >= CW'(len));
  assign push      = inflight && !redirect;
  assign pop       = dec_valid && dec_ready && !redirect;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      RST:   state_next = RUN;
      RUN: begin
        issue = credit_ok && !redirect_valid;
        if (redirect_valid) state_next = FLUSH;
      end
      FLUSH: state_next = redirect_valid ? FLUSH : RUN;
      default: state_next = RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RST;
      fetch_pc <= PC_INIT;
      head_pc  <= PC_INIT;
      inflight <= 1'b0;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc <= redirect_pc & 16'hFFFE;
        head_pc  <= redirect_pc & 16'hFFFE;
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) fetch_pc <= fetch_pc + 16'd6;
        if (pop)   head_pc  <= head_pc + {13'b0, len, 1'b0};
      end
    end
  end

  ifu_word_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect),
    .push    (push),
    .push_w0 (imem_inst),
    .push_w1 (imem_inst_1),
    .push_w2 (imem_inst_2),
    .pop     (pop),
    .pop_len (len),
    .head0   (head0),
    .head1   (head1),
    .head2   (head2),
    .count   (count)
  );

  assign imem_addr = fetch_pc;
  assign dec_inst  = head0;
  assign dec_ext1  = (len >= 2'd2) ? head1 : '0;
  assign dec_ext2  = (len == 2'd3) ? head2 : '0;
  assign dec_len   = len;
  assign dec_pc    = head_pc;

`ifdef IFU_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_fetches <= '0;
      stat_stalls  <= '0;
    end else begin
      if (issue && stat_fetches != 16'hFFFF) stat_fetches <= stat_fetches + 16'd1;
      if (dec_ready && !dec_valid && stat_stalls != 16'hFFFF) stat_stalls <= stat_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit with a queue-level reference model
module tb_inst_fetch_unit;

  localparam int QD = 8;

  logic        clk = 1'b0;
  logic        rst_n, redirect_valid, dec_ready, dec_valid;
  logic [15:0] redirect_pc, imem_addr, imem_inst, imem_inst_1, imem_inst_2;
  logic [15:0] dec_inst, dec_ext1, dec_ext2, dec_pc;
  logic [1:0]  dec_len;
`ifdef IFU_STATS_EN
  logic [15:0] stat_fetches, stat_stalls;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .imem_inst_1    (imem_inst_1),
    .imem_inst_2    (imem_inst_2),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_ext1       (dec_ext1),
    .dec_ext2       (dec_ext2),
    .dec_len        (dec_len),
    .dec_pc         (dec_pc)
`ifdef IFU_STATS_EN
    ,
    .stat_fetches   (stat_fetches),
    .stat_stalls    (stat_stalls)
`endif
  );

  // Registered three-word instruction memory.
  logic [15:0] mem [0:32767];
  always @(posedge clk) begin
    imem_inst   <= mem[imem_addr[15:1]];
    imem_inst_1 <= mem[15'(imem_addr[15:1] + 15'd1)];
    imem_inst_2 <= mem[15'(imem_addr[15:1] + 15'd2)];
  end

  typedef struct {
    logic [15:0] pc, inst, ext1, ext2;
    logic [1:0]  len;
  } pop_t;
  pop_t plog[$];

  // Reference model: a word queue plus PCs, updated once per clock from the rules.
  logic [15:0] mq[$];
  logic [15:0] m_fetch, m_head;
  logic [15:0] m_resp [3];
  bit          m_infl, m_known;
  int          m_mode;  // 0 reset/just released, 1 fetching, 2 flushing
  logic [15:0] m_fetches, m_stalls;
  int          n_cmp = 0, n_bad = 0;

  function automatic int len_of(input logic [15:0] w);
    if (w[15:14] == 2'b10) return 2;
    if (w[15:14] == 2'b11) return 3;
    return 1;
  endfunction

  function automatic int m_len();
    return (mq.size() > 0) ? len_of(mq[0]) : 1;
  endfunction

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq.size() >= m_len());
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_cycle();
    int l;
    bit v;
    l = m_len();
    v = m_valid();
    chk("imem_addr", 32'(imem_addr), 32'(m_fetch));
    chk("dec_pc", 32'(dec_pc), 32'(m_head));
    chk("dec_valid", 32'(dec_valid), 32'(v));
    if (v) begin
      chk("dec_inst", 32'(dec_inst), 32'(mq[0]));
      chk("dec_len", 32'(dec_len), 32'(l));
      chk("dec_ext1", 32'(dec_ext1), (l >= 2) ? 32'(mq[1]) : 32'd0);
      chk("dec_ext2", 32'(dec_ext2), (l == 3) ? 32'(mq[2]) : 32'd0);
    end
`ifdef IFU_STATS_EN
    chk("stat_fetches", 32'(stat_fetches), 32'(m_fetches));
    chk("stat_stalls", 32'(stat_stalls), 32'(m_stalls));
`endif
  endtask

  task automatic model_step();
    int l;
    bit v, redir, issue;
    if (!rst_n) begin
      mq.delete();
      m_fetch = 16'h0000; m_head = 16'h0000;
      m_infl = 1'b0; m_mode = 0; m_known = 1'b1;
      m_fetches = 16'h0; m_stalls = 16'h0;
      return;
    end
    l = m_len();
    v = m_valid();
    redir = redirect_valid && (m_mode != 0);
    issue = (m_mode == 1) && !redirect_valid && (mq.size() + 3 * int'(m_infl) + 3 <= QD);
    if (issue && m_fetches != 16'hFFFF) m_fetches++;
    if (dec_ready && !v && m_stalls != 16'hFFFF) m_stalls++;
    if (redir) begin
      mq.delete();
      m_infl  = 1'b0;
      m_fetch = redirect_pc & 16'hFFFE;
      m_head  = redirect_pc & 16'hFFFE;
      m_mode  = 2;
    end else begin
      if (v && dec_ready) begin
        repeat (l) void'(mq.pop_front());
        m_head += 16'(2 * l);
      end
      if (m_infl) for (int k = 0; k < 3; k++) mq.push_back(m_resp[k]);
      if (issue) begin
        for (int k = 0; k < 3; k++) m_resp[k] = mem[15'(m_fetch[15:1] + 15'(k))];
        m_fetch += 16'd6;
      end
      m_infl = issue;
      m_mode = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic rv, input logic [15:0] rpc, input logic rdy);
    pop_t p;
    @(negedge clk);
    rst_n = r; redirect_valid = rv; redirect_pc = rpc; dec_ready = rdy;
    #1;
    if (m_known) begin
      compare_cycle();
      if (rst_n && dec_valid && dec_ready && !redirect_valid) begin
        p.pc = dec_pc; p.inst = dec_inst; p.ext1 = dec_ext1; p.ext2 = dec_ext2; p.len = dec_len;
        plog.push_back(p);
      end
    end
    model_step();
  endtask

  task automatic do_reset(input int n);
    repeat (n) cycle(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic chk_pop(input int k, input logic [15:0] pc, input logic [15:0] inst,
                         input logic [1:0] len, input logic [15:0] e1, input logic [15:0] e2);
    chk($sformatf("pop%0d_present", k), 32'(plog.size() > k), 32'd1);
    if (plog.size() > k) begin
      chk($sformatf("pop%0d_pc", k), 32'(plog[k].pc), 32'(pc));
      chk($sformatf("pop%0d_inst", k), 32'(plog[k].inst), 32'(inst));
      chk($sformatf("pop%0d_len", k), 32'(plog[k].len), 32'(len));
      chk($sformatf("pop%0d_ext1", k), 32'(plog[k].ext1), 32'(e1));
      chk($sformatf("pop%0d_ext2", k), 32'(plog[k].ext2), 32'(e2));
    end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32768; i++) mem[i] = {2'b00, 14'(i)};
  endtask

  initial begin
    int first_v, g;
    logic [15:0] addrs[$];
    logic [15:0] next_addr;

    m_known = 1'b0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; dec_ready = 1'b0;

    // Reset fetch: sequential single-word instructions.
    fill_pattern();
    do_reset(3);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("rst_dec_inst", 32'(dec_inst), 32'h0);
    chk("rst_dec_ext1", 32'(dec_ext1), 32'h0);
    chk("rst_dec_ext2", 32'(dec_ext2), 32'h0);
    chk("rst_dec_len", 32'(dec_len), 32'h1);
    chk("rst_dec_pc", 32'(dec_pc), 32'h0);
    plog.delete();
    first_v = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      if (first_v < 0 && dec_valid) first_v = i;
    end
    // call 0 observes the pre-release state; the cycle after the first release edge is call 1
    chk("first_valid_cycle", 32'(first_v), 32'd3);
    for (int k = 0; k < 4; k++) chk_pop(k, 16'(2 * k), 16'(k), 2'd1, 16'h0, 16'h0);

    // Variable length.
    fill_pattern();
    mem[0] = 16'h8001; mem[1] = 16'h1111; mem[2] = 16'hC002; mem[3] = 16'h0033; mem[4] = 16'h0044;
    do_reset(2);
    plog.delete();
    repeat (10) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk_pop(0, 16'h0000, 16'h8001, 2'd2, 16'h1111, 16'h0000);
    chk_pop(1, 16'h0004, 16'hC002, 2'd3, 16'h0033, 16'h0044);
    chk_pop(2, 16'h000A, 16'h0005, 2'd1, 16'h0000, 16'h0000);

    // Backpressure then release: the stream must continue without loss or duplication.
    fill_pattern();
    do_reset(2);
    plog.delete();
    repeat (20) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("bp_no_pop_while_stalled", 32'(plog.size()), 32'd0);
    repeat (20) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk("bp_pop_count", 32'(plog.size() >= 10), 32'd1);
    for (int k = 0; k < plog.size(); k++) begin
      chk($sformatf("bp_seq%0d_inst", k), 32'(plog[k].inst), 32'(k));
      chk($sformatf("bp_seq%0d_pc", k), 32'(plog[k].pc), 32'(2 * k));
    end

    // Redirect while a response is in flight and a pop is offered at the same edge.
    fill_pattern();
    do_reset(2);
    g = 0;
    while (!(m_infl && m_valid()) && g < 20) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      g++;
    end
    chk("redir_setup_bound", 32'(g < 20), 32'd1);
    cycle(1'b1, 1'b1, 16'h0101, 1'b1);
    chk("redir_with_pop_valid", 32'(dec_valid), 32'd1);
    plog.delete();
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk("flush_imem_addr", 32'(imem_addr), 32'h0100);
    chk("flush_dec_pc", 32'(dec_pc), 32'h0100);
    chk("flush_dec_valid", 32'(dec_valid), 32'd0);
    repeat (8) cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk_pop(0, 16'h0100, 16'h0080, 2'd1, 16'h0, 16'h0);
    chk_pop(1, 16'h0102, 16'h0081, 2'd1, 16'h0, 16'h0);

    // Wrap-around of the fetch and decode PCs.
    cycle(1'b1, 1'b1, 16'hFFFC, 1'b1);
    plog.delete();
    addrs.delete();
    repeat (10) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      addrs.push_back(imem_addr);
    end
    chk("wrap_addr_first", 32'(addrs[0]), 32'hFFFC);
    next_addr = 16'hFFFC;
    foreach (addrs[i]) if (next_addr == 16'hFFFC && addrs[i] != 16'hFFFC) next_addr = addrs[i];
    chk("wrap_addr_next", 32'(next_addr), 32'h0002);
    chk_pop(0, 16'hFFFC, 16'h3FFE, 2'd1, 16'h0, 16'h0);
    chk_pop(1, 16'hFFFE, 16'h3FFF, 2'd1, 16'h0, 16'h0);
    chk_pop(2, 16'h0000, 16'h0000, 2'd1, 16'h0, 16'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    do_reset(2);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 19) == 0),
            16'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
